// File: rtl/string_print_engine_pkg.sv
// string_print_engine_pkg: shared types and constants for the string print
// engine and its byte-lane helper.
//   state_e           : engine FSM states
//   SYSCALL_PRINT_STR : syscall number that carries a string address
//   WORD_W / BYTE_W   : data memory word and character widths
package string_print_engine_pkg;

  localparam int unsigned SYSCALL_PRINT_STR = 4;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned BYTE_W            = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    EMIT,
    DONE,
    REARM
  } state_e;

endpackage

// File: rtl/string_print_engine_if.sv
// string_print_engine_if: memory read port plus character stream of the
// string print engine.
//   mem_req/mem_addr   : word read request and word-aligned address
//   mem_ack/mem_rdata  : read data valid strobe and data
//   char_valid/char_data/char_ready : ready/valid character stream
// Modports: master = engine side, slave = memory/console side.
interface string_print_engine_if;
  import string_print_engine_pkg::*;

  logic              mem_req;
  logic [WORD_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;
  logic              char_valid;
  logic [BYTE_W-1:0] char_data;
  logic              char_ready;

  modport master (
    output mem_req, mem_addr, char_valid, char_data,
    input  mem_ack, mem_rdata, char_ready
  );

  modport slave (
    input  mem_req, mem_addr, char_valid, char_data,
    output mem_ack, mem_rdata, char_ready
  );

endinterface

// File: rtl/string_print_engine_byte_lane_select.sv
// byte_lane_select: picks one byte out of a 32-bit word by byte offset.
//   word_i   : data word
//   offset_i : byte offset within the word (address bits 1:0)
//   byte_o   : selected byte
// BIG_ENDIAN = 0 puts offset 0 at bits 7:0; 1 puts offset 0 at bits 31:24.
module byte_lane_select
  import string_print_engine_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        offset_i,
  output logic [BYTE_W-1:0] byte_o
);

  logic [1:0] lane;

  always_comb begin
    // For a 2-bit offset, bitwise inversion equals 3 - offset.
    lane   = BIG_ENDIAN ? ~offset_i : offset_i;
    byte_o = word_i[{lane, 3'b000} +: BYTE_W];
  end

endmodule

// File: rtl/string_print_engine.sv
// string_print_engine: prints a NUL-terminated string from data memory.
// A nonzero print_addr starts a walk from that byte address; each word is
// fetched once and its bytes are emitted on the char stream until a NUL or
// MAX_LEN characters. The CPU is stalled while printing.
//   clk, rst_n    : clock, synchronous active-low reset
//   print_addr    : string base address, nonzero = request
//   bus (master)  : memory read port and character stream
//   stall_cpu     : pipeline stall while busy
//   done          : one-cycle pulse at string end
//   truncated     : pulses with done when MAX_LEN was reached
// Optional build macro STRPRINT_DISPLAY_EN echoes accepted characters and
// truncation warnings to the simulator console; ports and timing unchanged.
module string_print_engine
  import string_print_engine_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 1024,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_W-1:0]     print_addr,
  string_print_engine_if.master bus,
  output logic                  stall_cpu,
  output logic                  done,
  output logic                  truncated
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

  state_e            state_q,    state_d;
  logic [WORD_W-1:0] cur_addr_q, cur_addr_d;
  logic [WORD_W-1:0] word_buf_q, word_buf_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              trunc_q,    trunc_d;

  logic [BYTE_W-1:0] lane_byte;
  logic [WORD_W-1:0] next_addr;
  logic              mem_req;
  logic [WORD_W-1:0] mem_addr;
  logic              char_valid;
  logic [BYTE_W-1:0] char_data;

  byte_lane_select #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .word_i   (word_buf_q),
    .offset_i (cur_addr_q[1:0]),
    .byte_o   (lane_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      word_buf_q <= '0;
      count_q    <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      word_buf_q <= word_buf_d;
      count_q    <= count_d;
      trunc_q    <= trunc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    word_buf_d = word_buf_q;
    count_d    = count_q;
    trunc_d    = trunc_q;
    next_addr  = cur_addr_q + 32'd1;
    mem_req    = 1'b0;
    mem_addr   = '0;
    char_valid = 1'b0;
    char_data  = '0;
    stall_cpu  = 1'b0;
    done       = 1'b0;
    truncated  = 1'b0;

    case (state_q)
      IDLE: begin
        // Stall straight from the request so the syscall cannot retire.
        if (print_addr != '0) begin
          stall_cpu  = 1'b1;
          cur_addr_d = print_addr;
          count_d    = '0;
          trunc_d    = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        stall_cpu = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {cur_addr_q[WORD_W-1:2], 2'b00};
        if (bus.mem_ack) begin
          word_buf_d = bus.mem_rdata;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        stall_cpu = 1'b1;
        if (lane_byte == '0) begin
          state_d = DONE;
        end else if (count_q == CNT_W'(MAX_LEN)) begin
          trunc_d = 1'b1;
          state_d = DONE;
        end else begin
          char_valid = 1'b1;
          char_data  = lane_byte;
          if (bus.char_ready) begin
            cur_addr_d = next_addr;
            count_d    = count_q + CNT_W'(1);
            // Crossing into the next word needs a fresh fetch.
            if (next_addr[1:0] == 2'b00) state_d = REQ;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        truncated = trunc_q;
        state_d   = REARM;
      end
      REARM: begin
        // The handler holds the address while the syscall is held.
        if (print_addr == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = mem_addr;
  assign bus.char_valid = char_valid;
  assign bus.char_data  = char_data;

`ifdef STRPRINT_DISPLAY_EN
  logic [WORD_W-1:0] base_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_addr_q <= '0;
    end else begin
      if (state_q == IDLE && print_addr != '0) base_addr_q <= print_addr;
      if (char_valid && bus.char_ready) $write("%c", char_data);
      if (done && truncated)
        $display("string_print_engine: warning: string at 0x%08h truncated at %0d chars",
                 base_addr_q, MAX_LEN);
    end
  end
`else
`endif

endmodule
